mac_bist_ctrl: RTL and testbench

MAC_BIST_CTRL -- requirements
Module: mac_bist_ctrl

---
 rtl/mac_bist_pkg.sv | 27 ++
 rtl/bist_lfsr.sv | 38 +++
 rtl/mac_bist_ctrl.sv | 152 +++++++++++++++
 tb/tb_mac_bist_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_bist_pkg.sv
// Shared types and constants for the MAC processing-element self-test controller.
package mac_bist_pkg;

    // Controller states. Each pattern walks LOAD_W -> DRIVE -> WAIT -> CHECK.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } bist_state_e;

    // Right-shifting Fibonacci LFSR. Taps 16,14,13,11 map to state bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS         = 16'h002D;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // The error counter is 9 bits wide and saturates at its maximum value.
    localparam int unsigned  ERR_CNT_W = 9;
    localparam logic [8:0]   ERR_MAX   = 9'h1FF;

    // Returns the next LFSR state: the feedback bit enters at the top.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 16-bit pattern generator. It can be reloaded with the seed or advanced one step.
module bist_lfsr
    import mac_bist_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        adv_i,
    output logic [15:0] q_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next state: a load takes priority over an advance.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (adv_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // State register. Reset returns the generator to the seed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/mac_bist_ctrl.sv
// Self-test controller for a weight-stationary MAC processing element.
// Each pattern first loads the weight w, then drives activation a and partial sum p.
// It then checks bottom == a*w + p and right == a.
module mac_bist_ctrl
    import mac_bist_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned NUM_PATTERNS = 8,
    parameter logic [15:0] LFSR_SEED    = LFSR_DEFAULT_SEED,
    localparam int unsigned IDX_W       = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [IDX_W-1:0]     fail_index,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 pe_op2_select,
    output logic                 pe_out_select,
    output logic                 pe_stat_bit,
    output logic [WORD_SIZE-1:0] pe_left,
    output logic [WORD_SIZE-1:0] pe_top,
    input  logic [WORD_SIZE-1:0] pe_right,
    input  logic [WORD_SIZE-1:0] pe_bottom
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);

    bist_state_e            state_q, state_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
    logic [IDX_W-1:0]       fidx_q, fidx_d;
    logic                   fseen_q, fseen_d;
    logic                   lfsr_load;
    logic                   lfsr_adv;
    logic [15:0]            lfsr_val;
    logic [15:0]            swap_val;
    logic [WORD_SIZE-1:0]   pat_w, pat_a, pat_p, exp_result;
    logic                   mismatch;

    bist_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (lfsr_load),
        .adv_i  (lfsr_adv),
        .q_o    (lfsr_val)
    );

    // The current pattern and its golden result are derived from the live LFSR value.
    assign swap_val   = {lfsr_val[7:0], lfsr_val[15:8]};
    assign pat_w      = lfsr_val[WORD_SIZE-1:0];
    assign pat_a      = swap_val[WORD_SIZE-1:0];
    assign pat_p      = ~lfsr_val[WORD_SIZE-1:0];
    assign exp_result = pat_a * pat_w + pat_p;
    assign mismatch   = (pe_bottom != exp_result) || (pe_right != pat_a);

    // Sequencing and bookkeeping. A run is reseeded and cleared only from IDLE or DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        fidx_d    = fidx_q;
        fseen_d   = fseen_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD_W;
                    lfsr_load = 1'b1;
                    cnt_d     = '0;
                    err_d     = '0;
                    fidx_d    = '0;
                    fseen_d   = 1'b0;
                end
            end
            ST_LOAD_W: state_d = ST_DRIVE;
            ST_DRIVE:  state_d = ST_WAIT;
            ST_WAIT:   state_d = ST_CHECK;
            ST_CHECK: begin
                lfsr_adv = 1'b1;
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 9'd1;
                    end
                    if (!fseen_q) begin
                        fseen_d = 1'b1;
                        fidx_d  = cnt_q;
                    end
                end
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD_W;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and bookkeeping registers. Reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fseen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fseen_q <= fseen_d;
        end
    end

    // PE drive pattern for each state. The PE stays quiet in IDLE and DONE.
    always_comb begin
        busy          = 1'b0;
        pe_op2_select = 1'b0;
        pe_stat_bit   = 1'b0;
        pe_out_select = 1'b0;
        pe_left       = '0;
        pe_top        = '0;
        case (state_q)
            ST_LOAD_W: begin
                busy          = 1'b1;
                pe_op2_select = 1'b1;
                pe_out_select = 1'b1;
                pe_top        = pat_w;
            end
            ST_DRIVE, ST_WAIT, ST_CHECK: begin
                busy          = 1'b1;
                pe_stat_bit   = 1'b1;
                pe_out_select = 1'b1;
                pe_left       = pat_a;
                pe_top        = pat_p;
            end
            default: ;
        endcase
    end

    assign done       = (state_q == ST_DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign fail_index = fidx_q;

endmodule

// File: tb/tb_mac_bist_ctrl.sv
// Bench for mac_bist_ctrl. A behavioural weight-stationary PE with selectable faults
// answers the controller. Table-driven runs and hand sequences cover reset and held start.
module tb_mac_bist_ctrl;

    localparam int NP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [2:0]  fail_index;
    logic [8:0]  err_count;
    logic        pe_op2_select, pe_out_select, pe_stat_bit;
    logic [15:0] pe_left, pe_top, pe_right, pe_bottom;

    int n_cmp = 0;
    int n_err = 0;

    // Fault modes: 0 none, 1 multiplier stuck-at-0, 2 multiplier stuck-at-1,
    // 3 bit 0 of bottom flipped during pattern 5 only.
    int fault_mode = 0;

    mac_bist_ctrl #(.WORD_SIZE(16), .NUM_PATTERNS(NP), .LFSR_SEED(16'hACE1)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail_index    (fail_index),
        .err_count     (err_count),
        .pe_op2_select (pe_op2_select),
        .pe_out_select (pe_out_select),
        .pe_stat_bit   (pe_stat_bit),
        .pe_left       (pe_left),
        .pe_top        (pe_top),
        .pe_right      (pe_right),
        .pe_bottom     (pe_bottom)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural PE ----------------
    logic [15:0] pe_w_q;
    logic [15:0] pe_sum;
    int          pe_pat;

    always_comb begin
        pe_sum = pe_left * pe_w_q + pe_top;
        case (fault_mode)
            1: pe_sum = pe_top;
            2: pe_sum = 16'hFFFF + pe_top;
            3: if (pe_pat == 6) pe_sum = (pe_left * pe_w_q + pe_top) ^ 16'h0001;
            default: ;
        endcase
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pe_w_q    <= '0;
            pe_right  <= '0;
            pe_bottom <= '0;
            pe_pat    <= 0;
        end else begin
            if (!busy) pe_pat <= 0;
            else if (pe_op2_select) pe_pat <= pe_pat + 1;
            if (pe_op2_select) pe_w_q <= pe_top;
            pe_right  <= pe_left;
            pe_bottom <= pe_stat_bit ? pe_sum : pe_top;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] next_lfsr(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [15:0] mul_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
        logic [31:0] full;
        full = a * b + c;
        return full[15:0];
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        int          fault;
        bit          hold;
        bit          exp_pass;
        logic [8:0]  exp_err;
        bit          chk_err;
        logic [2:0]  exp_fidx;
        logic [15:0] exp_bot0;
    } vec_t;

    vec_t vecs[5];

    // One full run: per-cycle drive checks, first CHECK values, final verdict vs table and model.
    task automatic run_vec(input vec_t v);
        logic [15:0] s, w, a, p, good, bad;
        int          m_err, m_fidx;
        logic [22:0] exp_vec;
        int          guard;
        fault_mode = v.fault;
        s = 16'hACE1;
        m_err = 0;
        m_fidx = -1;
        start = 1'b1;
        for (int k = 0; k < 4 * NP; k++) begin
            @(negedge clk);
            if (k == 0 && !v.hold) start = 1'b0;
            w = s;
            a = {s[7:0], s[15:8]};
            p = ~s;
            if (k % 4 == 0) exp_vec = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 2'b00} | 23'(0);
            exp_vec = (k % 4 == 0) ? {3'b101, 1'b0, 1'b1, 2'b00, 16'h0000}
                                   : {3'b100, 1'b1, 1'b1, 2'b00, a};
            check($sformatf("%s ctl/left c%0d", v.name, k),
                  {busy, done, pe_op2_select, pe_stat_bit, pe_out_select, 2'b00, pe_left}, exp_vec);
            check($sformatf("%s top c%0d", v.name, k), pe_top, (k % 4 == 0) ? w : p);
            if (k == 3) begin
                check($sformatf("%s bottom0", v.name), pe_bottom, v.exp_bot0);
                check($sformatf("%s right0", v.name), pe_right, 16'hE1AC);
            end
            if (k % 4 == 3) begin
                good = mul_add(a, w, p);
                case (v.fault)
                    1: bad = p;
                    2: bad = 16'hFFFF + p;
                    3: bad = (k / 4 == 5) ? (good ^ 16'h0001) : good;
                    default: bad = good;
                endcase
                if (bad != good) begin
                    m_err++;
                    if (m_fidx < 0) m_fidx = k / 4;
                end
                s = next_lfsr(s);
            end
        end
        @(negedge clk);
        check($sformatf("%s done/busy", v.name), {done, busy}, 2'b10);
        check($sformatf("%s pass", v.name), pass, v.exp_pass);
        check($sformatf("%s fail_index", v.name), fail_index, v.exp_fidx);
        if (v.chk_err) check($sformatf("%s err_count", v.name), err_count, v.exp_err);
        check($sformatf("%s err vs model", v.name), err_count, 9'(m_err));
        check($sformatf("%s fidx vs model", v.name), fail_index, (m_fidx < 0) ? 3'd0 : 3'(m_fidx));
        check($sformatf("%s pe idle", v.name),
              {pe_op2_select, pe_stat_bit, pe_out_select, pe_left, pe_top}, '0);
        if (v.hold) begin
            // Start still high: exactly one DONE cycle, then a fresh run.
            @(negedge clk);
            check("hold restart", {busy, done, pe_op2_select, pe_top}, {3'b101, 16'hACE1});
            start = 1'b0;
            guard = 0;
            while (!done && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            check("hold rerun length", guard, 32);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{"clean",    0, 1'b0, 1'b1, 9'd0, 1'b1, 3'd0, 16'h3B4A};
        vecs[1] = '{"stuck0",   1, 1'b0, 1'b0, 9'd8, 1'b1, 3'd0, 16'h531E};
        vecs[2] = '{"stuck1",   2, 1'b0, 1'b0, 9'd0, 1'b0, 3'd0, 16'h531D};
        vecs[3] = '{"pat5",     3, 1'b0, 1'b0, 9'd1, 1'b1, 3'd5, 16'h3B4A};
        vecs[4] = '{"holdstart",0, 1'b1, 1'b1, 9'd0, 1'b1, 3'd0, 16'h3B4A};

        // Reset state
        #12;
        check("reset outputs",
              {busy, done, pass, fail_index, err_count, pe_op2_select, pe_out_select,
               pe_stat_bit, pe_left, pe_top}, '0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle after reset", {busy, done, pass}, 3'b000);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset during pattern 3 WAIT
        fault_mode = 0;
        start = 1'b1;
        repeat (15) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-reset in WAIT", {busy, pe_stat_bit, pe_op2_select}, 3'b110);
        #2 rst = 1'b0;
        #1;
        check("async reset outputs",
              {busy, done, pass, fail_index, err_count, pe_op2_select, pe_out_select,
               pe_stat_bit, pe_left, pe_top}, '0);
        #3 rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("no resume after reset", {busy, done}, 2'b00);
        end
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the bench cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
